// File: rtl/frame_buffer_sequencer.sv
// frame_buffer_sequencer: waits for a locked NTSC/PAL standard, loads the
// matching SDRAM window addresses, pulses the port reload and then gates the
// write strobe and the odd/even-field read strobes while locked.
module frame_buffer_sequencer #(
  parameter int LOCK_FRAMES = 4,
  parameter int LOAD_CYCLES = 16,
  parameter int ADDR_W      = 23
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iTD_Stable,
  input  logic              iNTSC,
  input  logic              iPAL,
  input  logic              iTD_VS,
  input  logic              iTV_DVAL,
  input  logic              iVGA_Read,
  input  logic              iVGA_Y0,
  output logic              oWR1,
  output logic              oRD1,
  output logic              oRD2,
  output logic              oLOAD,
  output logic [ADDR_W-1:0] oWR1_MAX_ADDR,
  output logic [ADDR_W-1:0] oRD1_ADDR,
  output logic [ADDR_W-1:0] oRD1_MAX_ADDR,
  output logic [ADDR_W-1:0] oRD2_ADDR,
  output logic [ADDR_W-1:0] oRD2_MAX_ADDR,
  output logic [1:0]        oMode,
  output logic              oReady,
  output logic [7:0]        oFrame_Cnt
);

  localparam int LCW = $clog2(LOCK_FRAMES + 1);
  localparam int LW  = $clog2(LOAD_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_FRAMES - 1);
  localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_FRAMES);
  localparam logic [LW-1:0]  LOAD_LAST = LW'(LOAD_CYCLES - 1);

  localparam logic [1:0] MODE_NONE = 2'd0;
  localparam logic [1:0] MODE_NTSC = 2'd1;
  localparam logic [1:0] MODE_PAL  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_DETECT, S_LOAD, S_RUN} state_e;

  // One SDRAM window set, as loaded into the port controller.
  typedef struct packed {
    logic [ADDR_W-1:0] wr1_max;
    logic [ADDR_W-1:0] rd1;
    logic [ADDR_W-1:0] rd1_max;
    logic [ADDR_W-1:0] rd2;
    logic [ADDR_W-1:0] rd2_max;
  } addr_set_t;

  localparam addr_set_t ADDR_NTSC = '{
    wr1_max: ADDR_W'(324480), rd1: ADDR_W'(8320),  rd1_max: ADDR_W'(161920),
    rd2:     ADDR_W'(170880), rd2_max: ADDR_W'(324480)};
  localparam addr_set_t ADDR_PAL = '{
    wr1_max: ADDR_W'(368640), rd1: ADDR_W'(26880), rd1_max: ADDR_W'(180480),
    rd2:     ADDR_W'(211200), rd2_max: ADDR_W'(364800)};

  state_e          state_q, state_d;
  logic [1:0]      cand_q, cand_d;
  logic [1:0]      mode_q, mode_d;
  logic [LCW-1:0]  lock_q, lock_d;
  logic [LW-1:0]   load_q, load_d;
  logic [7:0]      fcnt_q, fcnt_d;
  addr_set_t       addr_q, addr_d;
  logic            vs_q;

  logic       std_vld;
  logic [1:0] std;
  logic       fs;
  logic       run;

  // Standard decode: exactly one of NTSC/PAL with a stable decoder.
  assign std_vld = iTD_Stable & (iNTSC ^ iPAL);
  assign std     = iPAL ? MODE_PAL : MODE_NTSC;
  assign fs      = vs_q & ~iTD_VS;

  // Next-state logic; any loss or change of standard after lock drops to IDLE.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    mode_d  = mode_q;
    lock_d  = lock_q;
    load_d  = load_q;
    fcnt_d  = fcnt_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        mode_d = MODE_NONE;
        if (std_vld) begin
          cand_d  = std;
          lock_d  = '0;
          state_d = S_DETECT;
        end
      end
      S_DETECT: begin
        if (!std_vld) begin
          state_d = S_IDLE;
        end else if (std != cand_q) begin
          // A change in the same cycle as a frame start wins; frame not counted.
          cand_d = std;
          lock_d = '0;
        end else if (fs) begin
          if (lock_q >= LOCK_LAST) begin
            lock_d  = LOCK_FULL;
            load_d  = '0;
            mode_d  = cand_q;
            addr_d  = (cand_q == MODE_PAL) ? ADDR_PAL : ADDR_NTSC;
            state_d = S_LOAD;
          end else begin
            lock_d = lock_q + LCW'(1);
          end
        end
      end
      S_LOAD: begin
        if (!std_vld || std != mode_q) begin
          mode_d  = MODE_NONE;
          state_d = S_IDLE;
        end else if (load_q == LOAD_LAST) begin
          state_d = S_RUN;
        end else begin
          load_d = load_q + LW'(1);
        end
      end
      S_RUN: begin
        if (fs) fcnt_d = fcnt_q + 8'd1;
        if (!std_vld || std != mode_q) begin
          mode_d  = MODE_NONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      mode_q  <= '0;
      lock_q  <= '0;
      load_q  <= '0;
      fcnt_q  <= '0;
      addr_q  <= '0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      mode_q  <= mode_d;
      lock_q  <= lock_d;
      load_q  <= load_d;
      fcnt_q  <= fcnt_d;
      addr_q  <= addr_d;
      vs_q    <= iTD_VS;
    end
  end

  // Gates are combinational off the registered state: no added latency.
  assign run           = (state_q == S_RUN);
  assign oReady        = run;
  assign oLOAD         = (state_q == S_LOAD);
  assign oWR1          = run & iTV_DVAL;
  assign oRD1          = run & iVGA_Read & ~iVGA_Y0;
  assign oRD2          = run & iVGA_Read & iVGA_Y0;
  assign oMode         = mode_q;
  assign oFrame_Cnt    = fcnt_q;
  assign oWR1_MAX_ADDR = addr_q.wr1_max;
  assign oRD1_ADDR     = addr_q.rd1;
  assign oRD1_MAX_ADDR = addr_q.rd1_max;
  assign oRD2_ADDR     = addr_q.rd2;
  assign oRD2_MAX_ADDR = addr_q.rd2_max;

endmodule

// File: doc/frame_buffer_sequencer.md
# frame_buffer_sequencer

Controller that brings up and sequences the SDRAM frame-buffer ports of the TV-in/VGA-out pipeline. It watches decoder stability and the NTSC/PAL standard, waits for a locked standard, then selects that standard's window addresses. It pulses the port reload, opens the write path and steers VGA read requests to the odd-field or even-field read port. On loss of lock or a standard change it closes all gates and re-arms. It sits between the stability/standard detector, the VGA controller and the 4-port SDRAM controller.

## Interface
Parameters:
- LOCK_FRAMES, 4: consecutive frames with a constant, valid standard required before loading.
- LOAD_CYCLES, 16: width of the oLOAD pulse, in clocks.
- ADDR_W, 23: width of every address output.

Ports:
- iCLK  in  1  video clock (27 MHz decoder clock); all logic on the rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iTD_Stable  in  1  decoder stable flag.
- iNTSC  in  1  NTSC detected.
- iPAL  in  1  PAL detected.
- iTD_VS  in  1  decoder vertical sync, active-low; synchronous to iCLK.
- iTV_DVAL  in  1  decoded pixel valid.
- iVGA_Read  in  1  VGA pixel request.
- iVGA_Y0  in  1  VGA line LSB (0 = odd field, 1 = even field).
- oWR1  out  1  gated write strobe to the write port.
- oRD1  out  1  gated read strobe to the odd-field port.
- oRD2  out  1  gated read strobe to the even-field port.
- oLOAD  out  1  port reload, active-high.
- oWR1_MAX_ADDR  out  ADDR_W  write window end.
- oRD1_ADDR, oRD1_MAX_ADDR  out  ADDR_W  odd-field read window.
- oRD2_ADDR, oRD2_MAX_ADDR  out  ADDR_W  even-field read window.
- oMode  out  2  0 = none, 1 = NTSC, 2 = PAL.
- oReady  out  1  high in RUN.
- oFrame_Cnt  out  8  frames seen in RUN.

## Operation
- Frame start: falling edge of iTD_VS, detected against a one-cycle delayed copy.
- Valid standard: iTD_Stable=1 and exactly one of iNTSC/iPAL set. Both set or neither set is invalid.

State machine states: IDLE, DETECT, LOAD, RUN.
- IDLE: entered from reset. Moves to DETECT on the first cycle with a valid standard; the standard is latched into cand.
- DETECT:
  - Each frame start with a valid standard equal to cand increments lock_cnt.
  - A valid standard differing from cand (on any cycle) re-latches cand and sets lock_cnt=0.
  - An invalid standard returns to IDLE.
  - When lock_cnt reaches LOCK_FRAMES, the next state is LOAD; oMode and the address outputs take the values for cand.
- LOAD: oLOAD=1 for exactly LOAD_CYCLES cycles, then RUN.
- RUN:
  - oReady=1.
  - oFrame_Cnt increments on each frame start and wraps 255 to 0.
  - A standard that is invalid or differs from oMode goes to IDLE on the next cycle.
- Leaving RUN or LOAD for IDLE:
  - oMode=0 and oReady=0.
  - Address outputs hold their last values.
  - oFrame_Cnt is not cleared.
  - A LOAD interrupted by loss of lock truncates oLOAD.

Address values (held constant outside IDLE transitions):
- NTSC: WR1_MAX=324480, RD1=8320..161920, RD2=170880..324480.
- PAL: WR1_MAX=368640, RD1=26880..180480, RD2=211200..364800.
- Values are zero-extended to ADDR_W.

Gating:
- oWR1 = RUN & iTV_DVAL.
- oRD1 = RUN & iVGA_Read & ~iVGA_Y0.
- oRD2 = RUN & iVGA_Read & iVGA_Y0.
- oRD1 and oRD2 are never both high.
- The gates are combinational from registered state, with no added latency.

## Timing
- Reset values: all outputs 0; state IDLE; lock_cnt=0; cand=0.
- Reset assertion mid-operation clears everything immediately (asynchronous). Deassertion takes effect at the next iCLK edge.
- Lock latency: from the LOCK_FRAMES-th qualifying frame start (cycle T):
  - T+1: state is LOAD; oLOAD=1; addresses and oMode are valid.
  - T+LOAD_CYCLES: last cycle with oLOAD=1.
  - T+LOAD_CYCLES+1: oReady=1 and the gates open.
- A frame start in the same cycle as a standard change: the change wins; the frame is not counted.
- A frame start in LOAD: ignored. oFrame_Cnt starts counting in RUN.
- Loss of lock in RUN at cycle T: oReady and the gates are 0 at T+1.
- lock_cnt saturates; it never wraps.

## Test plan
- NTSC stable, 4 VS falling edges -> oLOAD high exactly 16 cycles starting the cycle after edge 4; then oReady=1, oMode=1, RD1_ADDR=8320, RD2_MAX=324480.
- PAL after reset -> oMode=2, WR1_MAX=368640, RD1_ADDR=26880, RD2_ADDR=211200.
- In DETECT after 3 NTSC frames, switch to PAL -> count restarts; oLOAD only after 4 further PAL frames.
- In RUN, pulse iTD_Stable low for 1 cycle -> oReady=0 and oRD1/oRD2/oWR1=0 the next cycle; full relock takes 4 frames plus 16 load cycles.
- In RUN, iVGA_Read=1 while toggling iVGA_Y0 -> oRD1 follows Y0=0, oRD2 follows Y0=1, never both high; iTV_DVAL passes to oWR1 in the same cycle.
- 256 frames in RUN -> oFrame_Cnt wraps to 0. iRST_N asserted during LOAD -> oLOAD drops asynchronously and all outputs read 0.
